// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared SPU types: default lane type, pack-stage action decode and
// width helper for lane counters.
package elixirchip_es1_spu_pkg;

  localparam int SPU_DATA_BITS = 8;
  typedef logic [SPU_DATA_BITS-1:0] spu_data_t;

  typedef enum logic [1:0] {
    PACK_HOLD,
    PACK_STORE,
    PACK_RESTART,
    PACK_EMIT
  } pack_act_e;

  function automatic int pack_cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_pack_buf.sv
// Staging buffer for the pack stage: clear-all plus single-lane write,
// clear applied first so a restarted group can land in lane 0 same cycle.
module elixirchip_es1_spu_op_pack_buf
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int  N          = 4,
  parameter int  DATA_BITS  = 8,
  parameter type data_t     = logic [DATA_BITS-1:0],
  parameter int  IDX_BITS   = pack_cnt_bits(N),
  parameter data_t CLEAR_DATA = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cke,
  input  logic                clr,
  input  logic                we,
  input  logic [IDX_BITS-1:0] waddr,
  input  data_t               wdata,
  output data_t [N-1:0]       lanes
);

  data_t [N-1:0] stage_d;
  data_t [N-1:0] stage_q;

  always_comb begin
    stage_d = stage_q;
    for (int i = 0; i < N; i++) begin
      if (clr) stage_d[i] = CLEAR_DATA;
      if (we && (waddr == IDX_BITS'(i))) stage_d[i] = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) stage_q[i] <= CLEAR_DATA;
    end else if (cke) begin
      stage_q <= stage_d;
    end
  end

  assign lanes = stage_q;

endmodule

// File: rtl/elixirchip_es1_spu_op_pack.sv
// SPU pack stage: gathers selected lanes into an N-lane word and emits it
// when full or on flush. EMPTY/FILLING is implied by cnt_q == 0.
module elixirchip_es1_spu_op_pack
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int  N          = 4,
  parameter int  DATA_BITS  = 8,
  parameter type data_t     = logic [DATA_BITS-1:0],
  parameter int  CNT_BITS   = pack_cnt_bits(N),
  parameter data_t CLEAR_DATA = '0,
  parameter      DEVICE     = "RTL",
  parameter      SIMULATION = "false",
  parameter      DEBUG      = "false"
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cke,
  input  data_t                  s_data,
  input  logic                   s_valid,
  input  logic                   s_clear,
  input  logic                   s_flush,
  output logic [N*DATA_BITS-1:0] m_data,
  output logic [CNT_BITS-1:0]    m_count,
  output logic                   m_valid
);

  localparam logic [CNT_BITS-1:0] N_CNT = CNT_BITS'(N);

  logic [CNT_BITS-1:0] cnt_d, cnt_q;
  logic [CNT_BITS-1:0] eff_cnt, k;
  logic                emit;
  pack_act_e           act;
  data_t [N-1:0]       stage, merged;
  data_t [N-1:0]       m_data_d, m_data_q;
  logic [CNT_BITS-1:0] m_count_d, m_count_q;
  logic                m_valid_d, m_valid_q;
  logic                buf_clr, buf_we;
  logic [CNT_BITS-1:0] buf_waddr;

  // A clear drops the old partial before the current beat is considered,
  // so clear+flush can only ever emit the beat present this cycle.
  always_comb begin
    eff_cnt = s_clear ? '0 : cnt_q;
    k       = eff_cnt + CNT_BITS'(s_valid);
    for (int i = 0; i < N; i++) begin
      merged[i] = s_clear ? CLEAR_DATA : stage[i];
      if (s_valid && (eff_cnt == CNT_BITS'(i))) merged[i] = s_data;
      if (CNT_BITS'(i) >= k) merged[i] = CLEAR_DATA;
    end
    emit = (k == N_CNT) || (s_flush && (k != '0));

    if (emit)         act = PACK_EMIT;
    else if (s_clear) act = PACK_RESTART;
    else if (s_valid) act = PACK_STORE;
    else              act = PACK_HOLD;

    buf_clr   = (act == PACK_EMIT) || (act == PACK_RESTART);
    buf_we    = (act == PACK_STORE) || ((act == PACK_RESTART) && s_valid);
    buf_waddr = eff_cnt;

    cnt_d     = emit ? '0 : k;
    m_valid_d = emit;
    m_data_d  = emit ? merged : m_data_q;
    m_count_d = emit ? k : m_count_q;
  end

  elixirchip_es1_spu_op_pack_buf #(
    .N          (N),
    .DATA_BITS  (DATA_BITS),
    .data_t     (data_t),
    .IDX_BITS   (CNT_BITS),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .clr     (buf_clr),
    .we      (buf_we),
    .waddr   (buf_waddr),
    .wdata   (s_data),
    .lanes   (stage)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_count_q <= '0;
      for (int i = 0; i < N; i++) m_data_q[i] <= CLEAR_DATA;
    end else if (cke) begin
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_count_q <= m_count_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_count = m_count_q;
  assign m_valid = m_valid_q;

  // Sanity checks only in simulation/debug builds of a named device.
  localparam bit CHECKS_ON = ((SIMULATION == "true") || (DEBUG == "true")) && (DEVICE != "");
  if (CHECKS_ON) begin : g_checks
    a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
      m_valid_q |-> ((m_count_q != '0) && (m_count_q <= N_CNT)));
  end

endmodule

// File: doc/elixirchip_es1_spu_op_pack.md
Name: elixirchip_es1_spu_op_pack

Overview:
- Downstream stage of the SPU select op.
- Collects the selected data stream (one data_t per accepted beat) into a packed vector of N lanes.
- Emits the vector with a one-cycle valid pulse when N beats have arrived, or earlier on flush.
- Used to rebuild wide words after per-lane selection, before write-back or the next wide op.

Parameters:
- N, 4, number of lanes per packed output word (N >= 2).
- DATA_BITS, 8, lane width.
- data_t, logic [DATA_BITS-1:0], lane type.
- CNT_BITS, $clog2(N+1), width of the lane-count output.
- CLEAR_DATA, '0, fill value for lanes not written in a flushed partial word.
- DEVICE, "RTL", device name.
- SIMULATION, "false", simulation switch.
- DEBUG, "false", debug switch.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous reset, active low.
- cke  in  1  clock enable; when low, all state is frozen.
- s_data  in  DATA_BITS  input lane data (sel output).
- s_valid  in  1  s_data is valid this cycle.
- s_clear  in  1  discard the partial word held in the block.
- s_flush  in  1  emit the partial word now.
- m_data  out  N*DATA_BITS  packed data, lane i = beat i of the group (data_t [N-1:0]).
- m_count  out  CNT_BITS  number of written lanes in m_data (1..N).
- m_valid  out  1  one-cycle pulse: m_data/m_count valid.

Interface decision: one clock (clk); reset is asynchronous and active-low (reset_n).

Behaviour:
- Reset (reset_n=0, asynchronous): m_valid=0, m_count=0, m_data all lanes = CLEAR_DATA. Internal fill counter cnt=0; staging buffer = CLEAR_DATA.
- All updates occur on posedge clk with cke=1. With cke=0, every register holds, including m_valid. A held m_valid=1 is not a new output: a consumer qualifies with cke, matching SPU pipeline convention.
- Fill counter cnt ranges 0..N-1 and is the lane index of the next beat.
- Accept (s_valid=1, no clear/flush):
  - buf[cnt] <= s_data.
  - If cnt==N-1: m_data <= buf with lane N-1 = s_data; m_count <= N; m_valid <= 1; cnt <= 0; buf <= CLEAR_DATA.
  - Else cnt <= cnt+1 and m_valid <= 0.
- Latency: 1 cycle from the cke-qualified edge accepting the completing beat to m_valid=1.
- Flush (s_flush=1):
  - The current beat, if s_valid, is included first.
  - If the resulting lane count k >= 1: emit m_data = buf with lanes k..N-1 = CLEAR_DATA; m_count=k; m_valid=1; cnt<=0; buf cleared.
  - If k==0 (empty, no beat): no output, m_valid=0.
  - A flush with the N-th beat is identical to a normal full emit (m_count=N).
- Clear (s_clear=1): cnt<=0, buf<=CLEAR_DATA, m_valid<=0; the partial word is discarded.
- Clear with s_valid: clear wins for the old partial, and the beat is stored as lane 0 of a new group (cnt<=1).
- Clear with flush: clear wins for the old partial. The flush applies only to a beat present that cycle, which is emitted alone with m_count=1.
- m_valid is never high on two consecutive cke-qualified cycles unless each has a completing beat or flush.
- m_data and m_count hold their last value while m_valid=0.
- Reset mid-group: the partial word is lost; the next beat after release starts at lane 0.
- Implicit state machine: EMPTY (cnt=0) / FILLING (cnt>0). No extra FSM register is needed.

Decomposition:
- Shared package elixirchip_es1_spu_pkg: lane data_t typedef helper and packed-vector typedef (data_t [N-1:0]).
- Sub-module elixirchip_es1_spu_op_pack_buf: staging buffer with lane write-enable and clear.
- Top: counter, clear/flush priority, output register.
- Checker: sva_elixirchip_es1_spu_op_pack, using the existing expected_delay-style model.

Test Plan (N=4, DATA_BITS=8):
- Reset release, then beats 11,22,33,44 on consecutive cycles -> one cycle after 44: m_valid=1, m_data={44,33,22,11}, m_count=4; m_valid=0 the next cycle.
- Beats A1,A2 then s_flush alone -> m_valid=1, m_data={00,00,A2,A1}, m_count=2. A following flush with no beat -> no m_valid.
- Beats 01,02,03, then cke=0 for 5 cycles with s_valid=1 and data FF, then cke=1 with beat 04 -> m_data={04,03,02,01}; FF never captured.
- Beats 10,20, then s_clear with s_valid and data 30, then beats 40,50,60 -> m_data={60,50,40,30}, m_count=4.
- Beats 5A,5B, then assert reset_n=0 asynchronously between edges -> outputs go to 0 immediately; after release, beats 1..4 -> m_data={04,03,02,01}.
- 4 beats where the 4th carries s_flush -> m_count=4, single m_valid pulse, cnt restarts at 0.
